// File: rtl/phase_sequencer.sv
// Multi-phase core controller: one-hot phase enables held PHASE_CYCLES clocks each,
// core reset/enable sequencing, halt/resume/restart handling and a counted flush pulse.
`timescale 1ns/1ps
module phase_sequencer #(
  parameter int unsigned NUM_PHASES   = 2,
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic                  internal_clock,
  input  logic                  reset_n,
  input  logic                  controller_enable,
  input  logic                  halted,
  input  logic                  resume,
  input  logic                  restart,
  input  logic                  flush_detected,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  core_reset,
  output logic                  core_enable,
  output logic                  flush,
  output logic                  running,
  output logic                  halted_out,
  output logic                  rotation_done,
  output logic [COUNT_W-1:0]    rotation_count
);

  localparam int unsigned P_W = (NUM_PHASES   > 1) ? $clog2(NUM_PHASES)   : 1;
  localparam int unsigned C_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned I_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned F_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [P_W-1:0] P_LAST = P_W'(NUM_PHASES - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(PHASE_CYCLES - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(RESET_CYCLES - 1);
  localparam logic [F_W-1:0] F_LAST = F_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [P_W-1:0]        p_q, p_d;
  logic [C_W-1:0]        cyc_q, cyc_d;
  logic [I_W-1:0]        icnt_q, icnt_d;
  logic                  halt_pend_q, halt_pend_d;
  logic                  restart_q, restart_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  rot_end_c;
  logic                  restart_c;

  logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
  logic                  core_reset_q, core_reset_d;
  logic                  core_enable_q, core_enable_d;
  logic                  running_q, running_d;
  logic                  halted_out_q, halted_out_d;
  logic                  rot_done_q, rot_done_d;
  logic                  flush_q, flush_d;
  logic [F_W-1:0]        fcnt_q, fcnt_d;
  logic                  fprev_q, fprev_d;
  logic                  frise_q, frise_d;

  // State register
  always_ff @(posedge internal_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      p_q           <= '0;
      cyc_q         <= '0;
      icnt_q        <= '0;
      halt_pend_q   <= 1'b0;
      restart_q     <= 1'b0;
      count_q       <= '0;
      phase_en_q    <= '0;
      core_reset_q  <= 1'b0;
      core_enable_q <= 1'b0;
      running_q     <= 1'b0;
      halted_out_q  <= 1'b0;
      rot_done_q    <= 1'b0;
      flush_q       <= 1'b0;
      fcnt_q        <= '0;
      fprev_q       <= 1'b0;
      frise_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      cyc_q         <= cyc_d;
      icnt_q        <= icnt_d;
      halt_pend_q   <= halt_pend_d;
      restart_q     <= restart_d;
      count_q       <= count_d;
      phase_en_q    <= phase_en_d;
      core_reset_q  <= core_reset_d;
      core_enable_q <= core_enable_d;
      running_q     <= running_d;
      halted_out_q  <= halted_out_d;
      rot_done_q    <= rot_done_d;
      flush_q       <= flush_d;
      fcnt_q        <= fcnt_d;
      fprev_q       <= fprev_d;
      frise_q       <= frise_d;
    end
  end

  // Next-state: restart outranks everything; a disabled edge freezes all but the restart latch
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    cyc_d       = cyc_q;
    icnt_d      = icnt_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;
    rot_end_c   = 1'b0;
    restart_c   = restart | restart_q;
    restart_d   = (state_q != ST_IDLE) && restart_c && !controller_enable;
    if (state_q == ST_IDLE) begin
      if (controller_enable) begin
        state_d = ST_INIT;
        icnt_d  = '0;
      end
    end else if (controller_enable) begin
      if (restart_c) begin
        state_d     = ST_INIT;
        icnt_d      = '0;
        halt_pend_d = 1'b0;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (icnt_q == I_LAST) begin
              state_d = ST_RUN;
              p_d     = '0;
              cyc_d   = '0;
            end else begin
              icnt_d = icnt_q + I_W'(1);
            end
          end
          ST_RUN: begin
            halt_pend_d = halt_pend_q | halted;
            if (cyc_q == C_LAST) begin
              cyc_d = '0;
              if (p_q == P_LAST) begin
                p_d       = '0;
                rot_end_c = 1'b1;
                count_d   = count_q + COUNT_W'(1);
                if (halt_pend_q | halted) begin
                  state_d     = ST_HALT;
                  halt_pend_d = 1'b0;
                end
              end else begin
                p_d = p_q + P_W'(1);
              end
            end else begin
              cyc_d = cyc_q + C_W'(1);
            end
          end
          ST_HALT: begin
            if (resume) begin
              state_d = ST_RUN;
              p_d     = '0;
              cyc_d   = '0;
            end
          end
          default: ;
        endcase
      end
    end
    if (state_d == ST_INIT) count_d = '0;
  end

  // Outputs from next state; flush pulse restarts on each registered rising edge
  always_comb begin
    phase_en_d = '0;
    if (state_d == ST_RUN && controller_enable) phase_en_d = NUM_PHASES'(1) << p_d;
    core_reset_d  = (state_d == ST_INIT);
    core_enable_d = (state_d != ST_IDLE);
    running_d     = (state_d == ST_RUN);
    halted_out_d  = (state_d == ST_HALT);
    rot_done_d    = rot_end_c;
    fprev_d       = flush_detected;
    frise_d       = flush_detected & ~fprev_q;
    flush_d       = flush_q;
    fcnt_d        = fcnt_q;
    if (frise_q) begin
      flush_d = 1'b1;
      fcnt_d  = F_LAST;
    end else if (flush_q) begin
      if (fcnt_q != '0) fcnt_d = fcnt_q - F_W'(1);
      else              flush_d = 1'b0;
    end
    if (state_d == ST_INIT) begin
      flush_d = 1'b0;
      fcnt_d  = '0;
      frise_d = 1'b0;
    end
  end

  assign phase_en       = phase_en_q;
  assign core_reset     = core_reset_q;
  assign core_enable    = core_enable_q;
  assign flush          = flush_q;
  assign running        = running_q;
  assign halted_out     = halted_out_q;
  assign rotation_done  = rot_done_q;
  assign rotation_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a 2-phase/2-cycle instance and a 4-phase/1-cycle instance,
// hand vectors plus random stimulus against a tick-based reference model.
`timescale 1ns/1ps
module tb_phase_sequencer;

  localparam int M_IDLE = 0, M_INIT = 1, M_RUN = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, i_en, i_halt, i_resume, i_restart, i_fd;
  logic [1:0]  ph_a;  logic [15:0] cnt_a;
  logic        cr_a, ce_a, fl_a, run_a, ho_a, rd_a;
  logic [3:0]  ph_b;  logic [1:0]  cnt_b;
  logic        cr_b, ce_b, fl_b, run_b, ho_b, rd_b;

  phase_sequencer #(.NUM_PHASES(2), .PHASE_CYCLES(2), .RESET_CYCLES(1),
                    .FLUSH_CYCLES(3), .COUNT_W(16)) u_a (
    .internal_clock(clk), .reset_n(rst_n), .controller_enable(i_en), .halted(i_halt),
    .resume(i_resume), .restart(i_restart), .flush_detected(i_fd), .phase_en(ph_a),
    .core_reset(cr_a), .core_enable(ce_a), .flush(fl_a), .running(run_a),
    .halted_out(ho_a), .rotation_done(rd_a), .rotation_count(cnt_a));

  phase_sequencer #(.NUM_PHASES(4), .PHASE_CYCLES(1), .RESET_CYCLES(2),
                    .FLUSH_CYCLES(1), .COUNT_W(2)) u_b (
    .internal_clock(clk), .reset_n(rst_n), .controller_enable(i_en), .halted(i_halt),
    .resume(i_resume), .restart(i_restart), .flush_detected(i_fd), .phase_en(ph_b),
    .core_reset(cr_b), .core_enable(ce_b), .flush(fl_b), .running(run_b),
    .halted_out(ho_b), .rotation_done(rd_b), .rotation_count(cnt_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase position is a tick count within the rotation
  int m_mode[2], m_init[2], m_tick[2], m_hreq[2], m_rreq[2];
  int m_cnt[2], m_rd[2], m_last[2], m_fl[2];
  int edge_n;
  logic prev_fd;

  function automatic int np(input int k); return (k == 0) ? 2 : 4; endfunction
  function automatic int pc(input int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int rc(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int fc(input int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int cm(input int k); return (k == 0) ? 65536 : 4; endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_init[k] = 0; m_tick[k] = 0; m_hreq[k] = 0; m_rreq[k] = 0;
      m_cnt[k] = 0; m_rd[k] = 0; m_last[k] = -1000; m_fl[k] = 0;
    end
    edge_n = 0;
    prev_fd = 1'b0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int rs_any;
      m_rd[k] = 0;
      if (m_mode[k] == M_IDLE) begin
        if (i_en) begin m_mode[k] = M_INIT; m_init[k] = rc(k); m_cnt[k] = 0; end
      end else begin
        rs_any = (i_restart || m_rreq[k] != 0) ? 1 : 0;
        if (!i_en) m_rreq[k] = rs_any;
        else if (rs_any != 0) begin
          m_mode[k] = M_INIT; m_init[k] = rc(k); m_cnt[k] = 0; m_hreq[k] = 0; m_rreq[k] = 0;
        end else begin
          m_rreq[k] = 0;
          case (m_mode[k])
            M_INIT: begin
              m_init[k] = m_init[k] - 1;
              if (m_init[k] == 0) begin m_mode[k] = M_RUN; m_tick[k] = 0; end
            end
            M_RUN: begin
              if (i_halt) m_hreq[k] = 1;
              m_tick[k] = m_tick[k] + 1;
              if (m_tick[k] == np(k) * pc(k)) begin
                m_tick[k] = 0;
                m_rd[k] = 1;
                m_cnt[k] = (m_cnt[k] + 1) % cm(k);
                if (m_hreq[k] != 0) begin m_mode[k] = M_HALT; m_hreq[k] = 0; end
              end
            end
            M_HALT: if (i_resume) begin m_mode[k] = M_RUN; m_tick[k] = 0; end
            default: ;
          endcase
        end
      end
      if (m_mode[k] == M_INIT) begin
        m_fl[k] = 0;
        m_last[k] = -1000;
      end else begin
        m_fl[k] = (edge_n - m_last[k] >= 1 && edge_n - m_last[k] <= fc(k)) ? 1 : 0;
        if (i_fd && !prev_fd) m_last[k] = edge_n;
      end
    end
    prev_fd = i_fd;
    edge_n++;
  endtask

  task automatic check_inst(input string tag, input int k, input logic [31:0] ph,
                            input logic [31:0] cr, input logic [31:0] ce, input logic [31:0] fl,
                            input logic [31:0] run, input logic [31:0] ho,
                            input logic [31:0] rd, input logic [31:0] cnt);
    int exp_ph;
    exp_ph = (m_mode[k] == M_RUN && i_en) ? (1 << (m_tick[k] / pc(k))) : 0;
    chk($sformatf("%s[%0d] phase_en", tag, k), ph, exp_ph);
    chk($sformatf("%s[%0d] core_reset", tag, k), cr, (m_mode[k] == M_INIT) ? 1 : 0);
    chk($sformatf("%s[%0d] core_enable", tag, k), ce, (m_mode[k] != M_IDLE) ? 1 : 0);
    chk($sformatf("%s[%0d] flush", tag, k), fl, m_fl[k]);
    chk($sformatf("%s[%0d] running", tag, k), run, (m_mode[k] == M_RUN) ? 1 : 0);
    chk($sformatf("%s[%0d] halted_out", tag, k), ho, (m_mode[k] == M_HALT) ? 1 : 0);
    chk($sformatf("%s[%0d] rotation_done", tag, k), rd, m_rd[k]);
    chk($sformatf("%s[%0d] rotation_count", tag, k), cnt, m_cnt[k]);
  endtask

  task automatic check_all(input string tag);
    check_inst(tag, 0, 32'(ph_a), 32'(cr_a), 32'(ce_a), 32'(fl_a), 32'(run_a), 32'(ho_a),
               32'(rd_a), 32'(cnt_a));
    check_inst(tag, 1, 32'(ph_b), 32'(cr_b), 32'(ce_b), 32'(fl_b), 32'(run_b), 32'(ho_b),
               32'(rd_b), 32'(cnt_b));
  endtask

  task automatic cycle(input string tag, input logic e, input logic h, input logic r,
                       input logic s, input logic f);
    @(negedge clk);
    i_en = e; i_halt = h; i_resume = r; i_restart = s; i_fd = f;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_en = 1'b0; i_halt = 1'b0; i_resume = 1'b0; i_restart = 1'b0; i_fd = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic en, hl, rs, rst, fd;
    int   ph, cr, run, ho, rd, cnt, fl;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic en, input logic hl, input logic rs, input logic rst,
                              input logic fd, input int ph, input int cr, input int run,
                              input int ho, input int rd, input int cnt, input int fl);
    vec_t v;
    v.en = en; v.hl = hl; v.rs = rs; v.rst = rst; v.fd = fd;
    v.ph = ph; v.cr = cr; v.run = run; v.ho = ho; v.rd = rd; v.cnt = cnt; v.fl = fl;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic e, h, r, s, f;
    rst_n = 1'b0;
    i_en = 1'b0; i_halt = 1'b0; i_resume = 1'b0; i_restart = 1'b0; i_fd = 1'b0;
    model_reset();
    // en hl rs rst fd | phase core_reset running halted_out rot_done count flush
    tv.push_back(mk(1,0,0,0,0, 0,1,0,0,0,0,0));  // INIT
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,1,1,0));
    tv.push_back(mk(1,1,0,0,0, 1,0,1,0,0,1,0));  // halt request mid-rotation
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,1,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,1,0));
    tv.push_back(mk(1,0,0,0,0, 0,0,0,1,1,2,0));  // HALT at rotation end
    tv.push_back(mk(1,1,0,0,0, 0,0,0,1,0,2,0));
    tv.push_back(mk(1,1,1,0,0, 1,0,1,0,0,2,0));  // resume beats halted
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,2,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,2,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,2,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,1,3,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,3,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,3,0));
    tv.push_back(mk(0,0,0,0,0, 0,0,1,0,0,3,0));  // frozen mid-phase
    tv.push_back(mk(0,0,0,0,0, 0,0,1,0,0,3,0));
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,3,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,1,4,0));
    tv.push_back(mk(1,0,0,1,0, 0,1,0,0,0,0,0));  // restart in RUN
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,0, 0,0,1,0,0,0,0));  // restart while frozen
    tv.push_back(mk(0,0,0,0,0, 0,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 0,1,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,1, 1,0,1,0,0,0,0));  // flush rise
    tv.push_back(mk(1,0,0,0,0, 2,0,1,0,0,0,1));
    tv.push_back(mk(1,0,0,0,1, 2,0,1,0,0,0,1));  // second rise
    tv.push_back(mk(1,0,0,0,1, 1,0,1,0,1,1,1));
    tv.push_back(mk(1,0,0,0,1, 1,0,1,0,0,1,1));
    tv.push_back(mk(1,0,0,0,1, 2,0,1,0,0,1,1));
    tv.push_back(mk(1,0,0,0,1, 2,0,1,0,0,1,0));
    tv.push_back(mk(1,0,0,0,1, 1,0,1,0,1,2,0));

    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    foreach (tv[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(t, tv[i].en, tv[i].hl, tv[i].rs, tv[i].rst, tv[i].fd);
      chk({t, " phase_en"},       32'(ph_a),  tv[i].ph);
      chk({t, " core_reset"},     32'(cr_a),  tv[i].cr);
      chk({t, " running"},        32'(run_a), tv[i].run);
      chk({t, " halted_out"},     32'(ho_a),  tv[i].ho);
      chk({t, " rotation_done"},  32'(rd_a),  tv[i].rd);
      chk({t, " rotation_count"}, 32'(cnt_a), tv[i].cnt);
      chk({t, " flush"},          32'(fl_a),  tv[i].fl);
    end

    // Four-phase instance: one-hot walk and 2-bit count wrap
    do_reset();
    for (int e4 = 0; e4 < 20; e4++) begin
      cycle("walk4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (e4 >= 2) begin
        chk($sformatf("walk4 e%0d phase_en", e4), 32'(ph_b), 1 << ((e4 - 2) % 4));
        chk($sformatf("walk4 e%0d count", e4), 32'(cnt_b), ((e4 - 2) / 4) % 4);
      end else begin
        chk($sformatf("walk4 e%0d core_reset", e4), 32'(cr_b), 1);
      end
    end

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      f = 1'b0;
      for (int n = 0; n < 400; n++) begin
        e = ($urandom_range(0, 9) != 0);
        h = ($urandom_range(0, 9) == 0);
        r = ($urandom_range(0, 4) == 0);
        s = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 2) == 0) f = ~f;
        cycle("rand", e, h, r, s, f);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
